line_pixel_writer: RTL and testbench
====================================

Name: line_pixel_writer

Overview:
- Consumer end of the line-rasteriser point stream. Accepts plotted Point2D samples with a plot strobe and a per-point colour, then clips them to the screen.
- Converts in-bounds points to linear framebuffer addresses, buffers them in a small FIFO and issues framebuffer write requests with a req/ack handshake.
- Pulses done once the line generator has signalled completion and every accepted pixel has been written.

Parameters:
SCREEN_W, 640, visible width in pixels; x valid range 0..SCREEN_W-1
SCREEN_H, 480, visible height in pixels; y valid range 0..SCREEN_H-1
FIFO_DEPTH, 8, pixel FIFO entries; power of two, >= 2
ADDR_W, 19, framebuffer address width
COLOR_W, 16, pixel colour width

Ports:
clk  input  1  clock
n_rst  input  1  reset, asynchronous, active-low
in_point  input  32  Point2D {x, y}, each a signed 16-bit shortint
in_plot  input  1  point valid strobe; one point per cycle when asserted
in_ready  output  1  writer can accept a point this cycle
in_color  input  COLOR_W  colour for the point on in_point
in_done  input  1  single-cycle pulse: line source finished
mem_addr  output  ADDR_W  framebuffer word address
mem_data  output  COLOR_W  pixel colour to write
mem_wr  output  1  write request; held until mem_ack
mem_ack  input  1  framebuffer accepted the current write
busy  output  1  FIFO non-empty, write in flight, or done pending
done  output  1  single-cycle completion pulse

Behaviour:
- Reset: FIFO empty, write FSM IDLE, done-pending flag clear, all outputs 0 except in_ready = 1.
- Accept: a point is taken when in_plot && in_ready. in_ready = !fifo_full, combinational from registered count.
- Clip:
  - An accepted point is discarded (not pushed) if x<0, y<0, x>=SCREEN_W or y>=SCREEN_H, using signed compares.
  - Discarded points still count as accepted.
- Push entry: {addr = y*SCREEN_W + x truncated to ADDR_W, in_color}, computed at push. The entry is visible at the head on the next cycle.
- Write FSM states: IDLE, WRITE.
  - IDLE -> WRITE when FIFO non-empty. mem_wr=1, mem_addr/mem_data driven from the FIFO head (registered outputs).
  - WRITE: hold mem_wr, mem_addr and mem_data stable until mem_ack.
  - On the mem_ack cycle, pop the head. If another entry remains, stay in WRITE and present it on the next cycle (back-to-back, mem_wr stays 1). Otherwise go to IDLE and drop mem_wr.
  - Minimum latency from accept to mem_wr = 2 cycles.
- mem_ack when mem_wr=0 is ignored.
- Push and pop in the same cycle are both performed; the count is unchanged.
- Full: in_ready=0. in_plot while not ready is ignored (no capture). The source must hold the point.
- Done:
  - in_done sets the done-pending flag.
  - When the flag is set, the FIFO is empty and the FSM is IDLE, done=1 for one cycle and the flag clears.
  - in_done coincident with an accepted point: the point is written before done.
  - in_done with nothing outstanding: done fires the next cycle.
  - A second in_done while pending is absorbed (one done pulse).
- busy = fifo non-empty | (state==WRITE) | done-pending.
- Reset mid-operation: FIFO flushed, mem_wr drops immediately (async), pending done lost, no done pulse.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1, distinguishing full from empty.

Optional Feature:
Macro PIXEL_WRITER_CLIP_STATS_EN.
- Defined:
  - Adds output clip_count (16 bits), counting points discarded by clipping since reset. Saturates at 16'hFFFF.
  - Cleared to 0 on the done pulse's following cycle only if a new accept occurs. Otherwise it holds its value, readable until the next in_plot accept after done.
- Not defined: port absent, no counter logic; clipping behaviour identical.

Test Plan:
- Single pixel (x=3,y=2), colour 16'hF800, mem_ack 1 cycle after mem_wr -> mem_wr rises 2 cycles after accept, mem_addr=1283, mem_data=16'hF800; in_done then gives done one cycle after the write completes.
- Burst of 10 points on consecutive cycles, mem_ack held low, FIFO_DEPTH=8 -> in_ready drops after the 8th accept, points 9-10 held by the source. Releasing mem_ack=1 writes all 10 in order back-to-back, then in_ready=1.
- Points (-1,5), (640,0), (0,480), (639,479) -> only addr 307199 is written; with PIXEL_WRITER_CLIP_STATS_EN, clip_count=3.
- in_done in the same cycle as the last accepted point (5,5) -> write addr 3205 completes, then done pulses exactly once; busy low the cycle after done.
- n_rst asserted while mem_wr=1 with 4 entries queued -> mem_wr, busy and done are 0 immediately, in_ready=1. After release, no stale writes are issued.
- mem_ack asserted while IDLE, and in_done with an empty FIFO -> no pop or underflow; done pulses the next cycle.

Source files
------------

// File: rtl/line_pixel_writer.sv
// Clips plotted points to the screen, queues framebuffer writes and issues them with req/ack; accept-to-mem_wr 2 cycles, in_ready low when FIFO full.
// Optional clip counter output clip_count enabled by `define PIXEL_WRITER_CLIP_STATS_EN.
module line_pixel_writer #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [31:0]        in_point,
  input  logic               in_plot,
  output logic               in_ready,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_wr,
  input  logic               mem_ack,
  output logic               busy,
  output logic               done
`ifdef PIXEL_WRITER_CLIP_STATS_EN
  ,
  output logic [15:0]        clip_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [15:0] W_S = 16'(SCREEN_W);
  localparam logic signed [15:0] H_S = 16'(SCREEN_H);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pix_t;

  typedef enum logic {IDLE, WRITE} state_t;

  pix_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, load_ptr;
  logic [CW-1:0] count;
  state_t        state, next_state;
  logic          pend;
  logic          pop, load;

  logic signed [15:0] px, py;
  logic               in_bounds, accept, push;
  pix_t               push_entry;

  assign px = in_point[31:16];
  assign py = in_point[15:0];

  assign in_bounds = (px >= 16'sd0) && (py >= 16'sd0) && (px < W_S) && (py < H_S);
  assign in_ready  = (count != CW'(FIFO_DEPTH));
  assign accept    = in_plot && in_ready;
  // Clipped points are consumed from the source but never reach the FIFO.
  assign push      = accept && in_bounds;

  assign push_entry.addr  = ADDR_W'(int'(py) * SCREEN_W + int'(px));
  assign push_entry.color = in_color;

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load       = 1'b0;
    load_ptr   = rd_ptr;
    case (state)
      IDLE: begin
        if (count != '0) begin
          next_state = WRITE;
          load       = 1'b1;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          pop = 1'b1;
          if (count > CW'(1)) begin
            load     = 1'b1;
            load_ptr = rd_ptr + PW'(1);
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign mem_wr = (state == WRITE);
  assign done   = pend && (count == '0) && (state == IDLE);
  assign busy   = (count != '0) || (state == WRITE) || pend;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_data <= '0;
      pend     <= 1'b0;
    end else begin
      state <= next_state;
      if (load) begin
        mem_addr <= fifo_mem[load_ptr].addr;
        mem_data <= fifo_mem[load_ptr].color;
      end
      // The completion pulse consumes the flag, so a repeat in_done while pending collapses into it.
      if (done)         pend <= 1'b0;
      else if (in_done) pend <= 1'b1;
    end
  end

`ifdef PIXEL_WRITER_CLIP_STATS_EN
  logic clr_arm;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clip_count <= '0;
      clr_arm    <= 1'b0;
    end else begin
      // After a done pulse the count stays readable until the next accept restarts it.
      if (accept) begin
        if (clr_arm)
          clip_count <= in_bounds ? 16'd0 : 16'd1;
        else if (!in_bounds && clip_count != 16'hFFFF)
          clip_count <= clip_count + 16'd1;
      end
      if (done)        clr_arm <= 1'b1;
      else if (accept) clr_arm <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_line_pixel_writer.sv
// Bench for line_pixel_writer: transaction-level reference model checked every cycle, directed cases plus random traffic.
module tb_line_pixel_writer;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int D  = 8;
  localparam int AW = 19;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [31:0]   in_point = '0;
  logic          in_plot = 1'b0;
  logic          in_ready;
  logic [CB-1:0] in_color = '0;
  logic          in_done = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [CB-1:0] mem_data;
  logic          mem_wr;
  logic          mem_ack = 1'b0;
  logic          busy;
  logic          done;
`ifdef PIXEL_WRITER_CLIP_STATS_EN
  logic [15:0]   clip_count;
`endif

  line_pixel_writer dut (
    .clk(clk), .n_rst(n_rst), .in_point(in_point), .in_plot(in_plot), .in_ready(in_ready),
    .in_color(in_color), .in_done(in_done), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr(mem_wr), .mem_ack(mem_ack), .busy(busy), .done(done)
`ifdef PIXEL_WRITER_CLIP_STATS_EN
    , .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CB-1:0] data;
  } wr_t;

  // Reference model: queue of writes owed to the framebuffer, in acceptance order.
  wr_t         q[$];
  wr_t         wlog[$];
  bit          pend;
  int unsigned clipm;
  bit          arm;
  bit          prev_wr, prev_ack;
  wr_t         prev_w;
  int          gap;

  function automatic bit inb(input logic [31:0] p);
    int x, y;
    x = int'($signed(p[31:16]));
    y = int'($signed(p[15:0]));
    return (x >= 0) && (x < W) && (y >= 0) && (y < H);
  endfunction

  function automatic wr_t entry_of(input logic [31:0] p, input logic [CB-1:0] c);
    wr_t e;
    int x, y;
    x = int'($signed(p[31:16]));
    y = int'($signed(p[15:0]));
    e.addr = AW'(y * W + x);
    e.data = c;
    return e;
  endfunction

  always @(negedge clk) begin
    bit acc, hs, dn;
    if (!n_rst) begin
      q.delete();
      pend = 0; clipm = 0; arm = 0; prev_wr = 0; prev_ack = 0; gap = 0;
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      chk("in_ready", in_ready, q.size() < D);
      chk("busy", busy, (q.size() > 0) || pend);
      chk("done", done, pend && (q.size() == 0));
      if (q.size() == 0) chk("wr_when_empty", mem_wr, 0);
      else if (mem_wr) begin
        chk("mem_addr", mem_addr, q[0].addr);
        chk("mem_data", mem_data, q[0].data);
      end
      if (prev_wr && !prev_ack) begin
        chk("wr_hold", mem_wr, 1);
        chk("addr_hold", {mem_addr, mem_data}, prev_w);
      end
      if (q.size() > 0 && !mem_wr) gap++; else gap = 0;
      if (q.size() > 0) chk("wr_start_gap", gap <= 1, 1);
`ifdef PIXEL_WRITER_CLIP_STATS_EN
      chk("clip_count", clip_count, clipm);
`endif
      acc = in_plot && (q.size() < D);
      hs  = mem_wr && mem_ack;
      dn  = pend && (q.size() == 0);
      if (hs && q.size() > 0) begin
        wlog.push_back({mem_addr, mem_data});
        void'(q.pop_front());
      end
      if (acc && inb(in_point)) q.push_back(entry_of(in_point, in_color));
      if (dn) pend = 0; else if (in_done) pend = 1;
      if (acc) begin
        if (arm) clipm = inb(in_point) ? 0 : 1;
        else if (!inb(in_point) && clipm != 32'hFFFF) clipm++;
      end
      if (dn) arm = 1; else if (acc) arm = 0;
      prev_wr = mem_wr; prev_ack = mem_ack; prev_w = {mem_addr, mem_data};
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic put(input int x, input int y, input logic [CB-1:0] c);
    in_point = {16'(x), 16'(y)};
    in_color = c;
    in_plot  = 1'b1;
  endtask

  task automatic take();
    bit a;
    a = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); a = in_ready;
      step();
      if (a) break;
    end
    chk("accept_timeout", a, 1);
    in_plot = 1'b0;
  endtask

  task automatic send(input int x, input int y, input logic [CB-1:0] c);
    put(x, y, c);
    take();
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_timeout", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nbad;
    bit seen, a;
    int x, y;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_mem_wr", mem_wr, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    step(); n_rst = 1'b1;
    step();

    // single pixel, 2-cycle latency
    put(3, 2, 16'hF800);
    step(); in_plot = 1'b0;
    @(negedge clk); chk("t1_wr_cycle1", mem_wr, 0);
    @(negedge clk);
    chk("t1_wr_cycle2", mem_wr, 1);
    chk("t1_addr", mem_addr, 1283);
    chk("t1_data", mem_data, 16'hF800);
    step(); mem_ack = 1'b1;
    @(negedge clk); chk("t1_wr_held", mem_wr, 1);
    step(); mem_ack = 1'b0; in_done = 1'b1;
    @(negedge clk); chk("t1_wr_dropped", mem_wr, 0); chk("t1_no_early_done", done, 0);
    step(); in_done = 1'b0;
    @(negedge clk); chk("t1_done", done, 1);
    step();
    @(negedge clk); chk("t1_done_once", done, 0); chk("t1_idle", busy, 0);

    // burst of 10 against a full FIFO
    wlog.delete();
    for (int i = 0; i < 8; i++) begin
      put(10 + i, 1, 16'(16'h0100 + i));
      step();
    end
    put(18, 1, 16'h0108);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t2_full", in_ready, 0);
      step();
    end
    mem_ack = 1'b1;
    take();
    send(19, 1, 16'h0109);
    wait_idle(200);
    chk("t2_count", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) begin
      chk("t2_addr", wlog[i].addr, 650 + i);
      chk("t2_data", wlog[i].data, 32'h0100 + i);
    end
    chk("t2_ready", in_ready, 1);

    // clipping
    wlog.delete();
    send(-1, 5, 16'h1111);
    send(640, 0, 16'h2222);
    send(0, 480, 16'h3333);
    send(639, 479, 16'h4444);
    wait_idle(100);
    chk("t3_count", wlog.size(), 1);
    if (wlog.size() > 0) chk("t3_addr", wlog[0].addr, 307199);
`ifdef PIXEL_WRITER_CLIP_STATS_EN
    chk("t3_clip_count", clip_count, 3);
`endif

    // in_done together with the last point
    wlog.delete();
    put(5, 5, 16'h07E0); in_done = 1'b1;
    step(); in_plot = 1'b0; in_done = 1'b0;
    nd = 0; seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (seen) begin chk("t4_busy_after_done", busy, 0); seen = 0; end
      if (done) begin nd++; seen = 1; chk("t4_written_first", wlog.size(), 1); end
    end
    chk("t4_done_pulses", nd, 1);
    if (wlog.size() > 0) chk("t4_addr", wlog[0].addr, 3205);

    // reset in the middle of a write
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) send(i, 10, 16'(16'h0A00 + i));
    in_done = 1'b1;
    step(); in_done = 1'b0;
    @(negedge clk); chk("t5_writing", mem_wr, 1);
    step(); #2 n_rst = 1'b0; #1;
    chk("t5_mem_wr", mem_wr, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_ready", in_ready, 1);
    repeat (2) step();
    n_rst = 1'b1; mem_ack = 1'b1;
    wlog.delete();
    nbad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_wr || done) nbad++;
    end
    chk("t5_no_stale", nbad, 0);
    chk("t5_no_writes", wlog.size(), 0);

    // ack while idle, done with nothing outstanding
    step(); in_done = 1'b1;
    step(); in_done = 1'b0;
    @(negedge clk); chk("t6_done", done, 1); chk("t6_mem_wr", mem_wr, 0); chk("t6_ready", in_ready, 1);
    step();
    @(negedge clk); chk("t6_done_once", done, 0); chk("t6_busy", busy, 0);

    // random traffic
    mem_ack = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); a = in_plot && in_ready;
      step();
      if (!in_plot || a) begin
        if ($urandom_range(0, 99) < 60) begin
          if ($urandom_range(0, 19) == 0) x = int'($signed(16'($urandom)));
          else x = int'($urandom_range(0, W + 40)) - 20;
          if ($urandom_range(0, 19) == 0) y = int'($signed(16'($urandom)));
          else y = int'($urandom_range(0, H + 40)) - 20;
          put(x, y, 16'($urandom));
        end else in_plot = 1'b0;
      end
      mem_ack = (((c / 400) % 2) == 0) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 15);
      in_done = ($urandom_range(0, 99) < 2);
    end
    in_plot = 1'b0; in_done = 1'b0; mem_ack = 1'b1;
    wait_idle(300);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
